// File: rtl/lfsr_rr_server_if.sv
// Handshake bundle for lfsr_rr_server: control/request inputs and grant/data outputs.
// The master modport drives requests; the slave modport is the server side.
interface lfsr_rr_server_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
);
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic [15:0]      words_issued;

  modport master (
    output en,
    output seed_load,
    output seed,
    output req,
    input  gnt,
    input  data,
    input  busy,
    input  words_issued
  );

  modport slave (
    input  en,
    input  seed_load,
    input  seed,
    input  req,
    output gnt,
    output data,
    output busy,
    output words_issued
  );
endinterface

// File: rtl/lfsr_rr_server.sv
// Shares one Galois LFSR among N_REQ requesters with round-robin grants, seeding and warm-up.
// Optional macro LFSR_STATS_EN builds a saturating grant counter on words_issued.
module lfsr_rr_server #(
  parameter int unsigned WIDTH  = 8,
  parameter logic [31:0] POLY   = 32'h0000_00c3,
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WARMUP = 4
) (
  input logic             clk,
  input logic             rst_n,
  lfsr_rr_server_if.slave bus
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] PolyW = POLY[WIDTH-1:0];
  localparam logic [7:0] WarmupW = 8'(WARMUP);

  typedef enum logic [1:0] {StWarmup, StServe, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [PtrW-1:0]  winner;
  logic [PtrW-1:0]  idx;
  logic             grant;

  // All-zero is part of the sequence: the inverted MSB re-enters at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] t;
    t = r ^ ({WIDTH{r[WIDTH-1]}} & PolyW);
    return {t[WIDTH-2:0], ~r[WIDTH-1]};
  endfunction

  // A requester granted this cycle is masked so continuous req alternates with others.
  assign eligible = bus.req & ~gnt_q;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    grant   = 1'b0;
    if (bus.seed_load) begin
      lfsr_d  = bus.seed;
      wcnt_d  = '0;
      state_d = StWarmup;
    end else begin
      unique case (state_q)
        StWarmup: begin
          if (wcnt_q == WarmupW) begin
            state_d = bus.en ? StServe : StHold;
          end else begin
            lfsr_d = lfsr_step(lfsr_q);
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        StServe: begin
          if (!bus.en) begin
            state_d = StHold;
          end else if (found) begin
            grant  = 1'b1;
            gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            data_d = lfsr_q;
            lfsr_d = lfsr_step(lfsr_q);
            ptr_d  = PtrW'((32'(winner) + 32'd1) % N_REQ);
          end
        end
        StHold: begin
          if (bus.en) state_d = StServe;
        end
        default: state_d = StWarmup;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWarmup;
      lfsr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.data = data_q;
  assign bus.busy = (state_q == StWarmup);

`ifdef LFSR_STATS_EN
  logic [15:0] words_q, words_d;

  always_comb begin
    words_d = words_q;
    if (bus.seed_load) begin
      words_d = '0;
    end else if (grant && (words_q != 16'hFFFF)) begin
      words_d = words_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign bus.words_issued = words_q;
`else
  logic unused_grant;
  assign unused_grant     = grant;
  assign bus.words_issued = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Scoreboard bench for lfsr_rr_server: a behavioural model queues the expected outputs of
// every cycle, and a monitor on the falling edge pops and compares them.
module tb_lfsr_rr_server;
  localparam int WIDTH  = 8;
  localparam int N_REQ  = 4;
  localparam int WARMUP = 4;
  localparam int POLY   = 'hC3;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] words;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  lfsr_rr_server_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  lfsr_rr_server #(
    .WIDTH (WIDTH),
    .POLY  (32'h0000_00c3),
    .N_REQ (N_REQ),
    .WARMUP(WARMUP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Galois step straight from the defining equation, in integer arithmetic.
  function automatic int next_word(input int r);
    if (r >= 128) return ((r ^ POLY) * 2) % 256;
    return (r * 2 + 1) % 256;
  endfunction

  // Behavioural model: mode 0 = warming up, 1 = serving, 2 = holding.
  int       m_mode, m_steps, m_lfsr, m_ptr, m_last, m_data, m_words, granted, idx;
  logic [3:0] req_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_steps = 0; m_lfsr = 0; m_ptr = 0; m_last = -1; m_data = 0; m_words = 0;
      sb.delete();
    end else begin
      granted = -1;
      req_v   = bus.req;
      if (bus.seed_load) begin
        m_lfsr  = int'(bus.seed);
        m_mode  = 0;
        m_steps = 0;
        m_words = 0;
      end else if (m_mode == 0) begin
        if (m_steps == WARMUP) m_mode = bus.en ? 1 : 2;
        else begin
          m_lfsr = next_word(m_lfsr);
          m_steps++;
        end
      end else if (m_mode == 2) begin
        if (bus.en) m_mode = 1;
      end else if (!bus.en) begin
        m_mode = 2;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (granted < 0 && req_v[idx[1:0]] && idx != m_last) granted = idx;
        end
        if (granted >= 0) begin
          m_data = m_lfsr;
          m_lfsr = next_word(m_lfsr);
          m_ptr  = (granted + 1) % N_REQ;
`ifdef LFSR_STATS_EN
          if (m_words < 65535) m_words++;
`endif
        end
      end
      m_last = granted;
      sb.push_back('{gnt:   (granted >= 0) ? 4'(1 << granted) : 4'b0,
                     data:  8'(m_data),
                     busy:  (m_mode == 0),
                     words: 16'(m_words)});
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset gnt", 32'(bus.gnt), 32'h0);
      check("reset data", 32'(bus.data), 32'h0);
      check("reset busy", 32'(bus.busy), 32'h1);
      check("reset words", 32'(bus.words_issued), 32'h0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      check("gnt", 32'(bus.gnt), 32'(e.gnt));
      check("data", 32'(bus.data), 32'(e.data));
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("words", 32'(bus.words_issued), 32'(e.words));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] gnt_tab [5];
  logic [7:0] data_tab [5];
  logic [3:0] r;

  initial begin
    vectors = 0; miscompares = 0;
    gnt_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    data_tab = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    rst_n = 1'b0;
    bus.en = 1'b1; bus.seed_load = 1'b0; bus.seed = '0; bus.req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Warm-up with no requests, then idle: LFSR must sit at 0F.
    repeat (12) @(negedge clk);

    // All four requesting: rotating grants on consecutive cycles.
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("rr gnt", 32'(bus.gnt), 32'(gnt_tab[j]));
      check("rr data", 32'(bus.data), 32'(data_tab[j]));
    end
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);

    // Single continuous requester: one word every other cycle.
    bus.req = 4'b0001;
    repeat (8) @(negedge clk);

    // Seed load while all request.
    bus.req = 4'b1111;
    repeat (3) @(negedge clk);
    bus.seed_load = 1'b1; bus.seed = 8'hFF;
    @(negedge clk);
    bus.seed_load = 1'b0;
    repeat (12) @(negedge clk);

    // Hold mid-stream and resume.
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    bus.en = 1'b1;
    repeat (6) @(negedge clk);

    // en low across a warm-up: warm-up completes, then holds.
    bus.seed_load = 1'b1; bus.seed = 8'h00; bus.en = 1'b0;
    @(negedge clk);
    bus.seed_load = 1'b0;
    repeat (10) @(negedge clk);
    bus.en = 1'b1;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of traffic.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Randomized traffic; requesters sometimes drop req in their grant cycle.
    for (int c = 0; c < 800; c++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) r = r & ~bus.gnt;
      bus.req       = r;
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.seed_load = ($urandom_range(0, 59) == 0);
      bus.seed      = 8'($urandom);
      @(negedge clk);
    end
    bus.seed_load = 1'b0;
    bus.en = 1'b1;

`ifdef LFSR_STATS_EN
    // Saturate the grant counter, then clear it with a seed load.
    bus.req = 4'b1111;
    repeat (66000) @(negedge clk);
    check("words saturated", 32'(bus.words_issued), 32'h0000FFFF);
    bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    check("words cleared", 32'(bus.words_issued), 32'h0);
`endif

    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
